// File: rtl/disp_pkg.sv
// Shared 7-segment glyphs and hex decode table for the scan counter display.
// Bit order: bit7..bit1 = segments a..g, bit0 = dp; all active-high.
package disp_pkg;

  localparam logic [7:0] SEG_BLANK = 8'h00;
  localparam logic [7:0] SEG_r     = 8'b0000_1010;
  localparam logic [7:0] SEG_u     = 8'b0011_1000;
  localparam logic [7:0] SEG_n     = 8'b0010_1010;
  localparam logic [7:0] SEG_H     = 8'b0110_1110;
  localparam logic [7:0] SEG_L     = 8'b0001_1100;
  localparam logic [7:0] SEG_t     = 8'b0001_1110;

  function automatic logic [7:0] hex_to_seg(input logic [3:0] nib);
    case (nib)
      4'h0:    return 8'b1111_1100;
      4'h1:    return 8'b0110_0000;
      4'h2:    return 8'b1101_1010;
      4'h3:    return 8'b1111_0010;
      4'h4:    return 8'b0110_0110;
      4'h5:    return 8'b1011_0110;
      4'h6:    return 8'b1011_1110;
      4'h7:    return 8'b1110_0000;
      4'h8:    return 8'b1111_1110;
      4'h9:    return 8'b1111_0110;
      4'hA:    return 8'b1110_1110;
      4'hB:    return 8'b0011_1110;
      4'hC:    return 8'b1001_1100;
      4'hD:    return 8'b0111_1010;
      4'hE:    return 8'b1001_1110;
      default: return 8'b1000_1110;
    endcase
  endfunction

  // Status word occupies the three leftmost digits: "run" or "HLt".
  function automatic logic [7:0] status_char(input int idx, input logic halt);
    case (idx)
      0:       return halt ? SEG_H : SEG_r;
      1:       return halt ? SEG_L : SEG_u;
      default: return halt ? SEG_t : SEG_n;
    endcase
  endfunction

endpackage

// File: rtl/seg7_hex_dec.sv
// Combinational hex nibble to 7-segment decoder (dp always off).
module seg7_hex_dec
  import disp_pkg::*;
(
  input  logic [3:0] nib,
  output logic [7:0] seg
);

  assign seg = hex_to_seg(nib);

endmodule

// File: rtl/scan_counter_display.sv
// Halt-gated cycle counter with a time-multiplexed multi-bank 7-segment readout.
// Optional build macro ZERO_BLANK_EN enables leading-zero suppression of counter digits.
module scan_counter_display
  import disp_pkg::*;
#(
  parameter int CNT_W    = 32,
  parameter int BANKS    = 2,
  parameter int DPB      = 4,
  parameter int SCAN_DIV = 1,
  parameter int NIB_OFS  = 0
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   halting,
  input  logic                   clear,
  output logic [CNT_W-1:0]       count,
  output logic                   ovf,
  output logic [8*BANKS-1:0]     seg,
  output logic [BANKS*DPB-1:0]   led_sel
);

  localparam int ND     = BANKS * DPB;
  localparam int SLOT_W = (DPB > 1) ? $clog2(DPB) : 1;
  localparam int PRE_W  = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  logic [CNT_W-1:0]   count_reg;
  logic               ovf_reg;
  logic [PRE_W-1:0]   pre_reg;
  logic [SLOT_W-1:0]  slot_reg;
  logic [SLOT_W-1:0]  slot_next;
  logic               disp_en_reg;
  logic [8*BANKS-1:0] seg_reg;
  logic [8*BANKS-1:0] seg_next;
  logic [ND-1:0]      led_reg;
  logic [ND-1:0]      led_next;
  logic               scan_tick;
  logic [3:0]         digit_nib [ND];
  logic [ND-1:0]      digit_blank;

  always_ff @(posedge clock) begin
    if (reset) begin
      count_reg <= '0;
      ovf_reg   <= 1'b0;
    end else if (clear) begin
      count_reg <= '0;
      ovf_reg   <= 1'b0;
    end else if (!halting) begin
      count_reg <= count_reg + CNT_W'(1);
      if (&count_reg) ovf_reg <= 1'b1;
    end
  end

  assign scan_tick = disp_en_reg && (pre_reg == PRE_W'(SCAN_DIV - 1));
  assign slot_next = (slot_reg == SLOT_W'(DPB - 1)) ? '0 : slot_reg + SLOT_W'(1);

  // Select and segments load together on the scan tick, so they never skew.
  always_ff @(posedge clock) begin
    if (reset) begin
      pre_reg     <= '0;
      slot_reg    <= '0;
      disp_en_reg <= 1'b0;
      seg_reg     <= '0;
      led_reg     <= '1;
    end else begin
      disp_en_reg <= 1'b1;
      if (scan_tick) begin
        pre_reg  <= '0;
        slot_reg <= slot_next;
        seg_reg  <= seg_next;
        led_reg  <= led_next;
      end else if (disp_en_reg) begin
        pre_reg <= pre_reg + PRE_W'(1);
      end
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < ND; gi++) begin : g_digit
      if (gi < 3) begin : g_status
        assign digit_nib[gi]   = 4'h0;
        assign digit_blank[gi] = 1'b0;
      end else begin : g_counter
        assign digit_nib[gi] = count_reg[4*(ND-1-gi+NIB_OFS) +: 4];
        if (gi == ND - 1) begin : g_lsd
          assign digit_blank[gi] = 1'b0;
        end else begin : g_upper
`ifdef ZERO_BLANK_EN
          // Blank when this digit and every more-significant displayed digit is zero.
          localparam int TOP = 4*(ND-3+NIB_OFS) - 1;
          assign digit_blank[gi] = (count_reg[TOP : 4*(ND-1-gi+NIB_OFS)] == '0);
`else
          assign digit_blank[gi] = 1'b0;
`endif
        end
      end
    end

    for (gi = 0; gi < BANKS; gi++) begin : g_bank
      logic [3:0] nib_sel;
      logic [7:0] dec_seg;
      logic [7:0] char_sel;
      logic       use_char;
      logic       blank_sel;

      always_comb begin
        nib_sel   = 4'h0;
        char_sel  = SEG_BLANK;
        use_char  = 1'b0;
        blank_sel = 1'b0;
        for (int s = 0; s < DPB; s++) begin
          if (slot_next == SLOT_W'(s)) begin
            nib_sel   = digit_nib[gi*DPB + s];
            blank_sel = digit_blank[gi*DPB + s];
            if (gi*DPB + s < 3) begin
              use_char = 1'b1;
              char_sel = status_char(gi*DPB + s, halting);
            end
          end
        end
      end

      seg7_hex_dec u_dec (
        .nib (nib_sel),
        .seg (dec_seg)
      );

      assign seg_next[8*gi +: 8]    = use_char ? char_sel : (blank_sel ? SEG_BLANK : dec_seg);
      assign led_next[gi*DPB +: DPB] = ~(DPB'(1) << slot_next);
    end
  endgenerate

  assign count   = count_reg;
  assign ovf     = ovf_reg;
  assign seg     = seg_reg;
  assign led_sel = led_reg;

endmodule

// File: tb/tb_scan_counter_display.sv
// Bench for scan_counter_display: two configurations checked every cycle against an arithmetic model.
module tb_scan_counter_display;

  localparam int NDUT = 2;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        halting = 1'b0;
  logic        clear = 1'b0;
  logic [31:0] count_a;
  logic        ovf_a;
  logic [15:0] seg_a;
  logic [7:0]  led_a;
  logic [11:0] count_b;
  logic        ovf_b;
  logic [7:0]  seg_b;
  logic [3:0]  led_b;

  int tests = 0;
  int fails = 0;

  always #5 clock = ~clock;

  scan_counter_display #(.CNT_W(32), .BANKS(2), .DPB(4), .SCAN_DIV(1), .NIB_OFS(0)) dut_a (
    .clock(clock), .reset(reset), .halting(halting), .clear(clear),
    .count(count_a), .ovf(ovf_a), .seg(seg_a), .led_sel(led_a)
  );

  scan_counter_display #(.CNT_W(12), .BANKS(1), .DPB(4), .SCAN_DIV(4), .NIB_OFS(0)) dut_b (
    .clock(clock), .reset(reset), .halting(halting), .clear(clear),
    .count(count_b), .ovf(ovf_b), .seg(seg_b), .led_sel(led_b)
  );

  int p_cw  [NDUT] = '{32, 12};
  int p_nb  [NDUT] = '{2, 1};
  int p_dpb [NDUT] = '{4, 4};
  int p_div [NDUT] = '{1, 4};

  logic [7:0] hex_tab [16] = '{8'hFC, 8'h60, 8'hDA, 8'hF2, 8'h66, 8'hB6, 8'hBE, 8'hE0,
                               8'hFE, 8'hF6, 8'hEE, 8'h3E, 8'h9C, 8'h7A, 8'h9E, 8'h8E};
  logic [7:0] run_tab [3] = '{8'h0A, 8'h38, 8'h2A};
  logic [7:0] hlt_tab [3] = '{8'h6E, 8'h1C, 8'h1E};

  logic [63:0] m_cnt  [NDUT];
  logic        m_ovf  [NDUT];
  int          m_pre  [NDUT];
  int          m_slot [NDUT];
  logic        m_den  [NDUT];
  logic [15:0] m_seg  [NDUT];
  logic [7:0]  m_led  [NDUT];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] exp_digit(input int d, input int g, input logic [63:0] cnt,
                                           input logic halt);
    int          nd;
    logic [63:0] upper;
    nd = p_nb[d] * p_dpb[d];
    if (g < 3) return halt ? hlt_tab[g] : run_tab[g];
    // Value formed by this digit and all displayed digits to its left.
    upper = (cnt >> (4 * (nd - 1 - g))) & ((64'd1 << (4 * (g - 2))) - 64'd1);
`ifdef ZERO_BLANK_EN
    if (g <= nd - 2 && upper == 64'd0) return 8'h00;
`endif
    return hex_tab[upper[3:0]];
  endfunction

  task automatic model_step(input int d);
    int          nd;
    logic [63:0] maxv;
    nd   = p_nb[d] * p_dpb[d];
    maxv = (64'd1 << p_cw[d]) - 64'd1;
    if (reset) begin
      m_cnt[d] = 0; m_ovf[d] = 0; m_pre[d] = 0; m_slot[d] = 0; m_den[d] = 0;
      m_seg[d] = 0; m_led[d] = 8'hFF >> (8 - nd);
    end else begin
      if (m_den[d]) begin
        if (m_pre[d] == p_div[d] - 1) begin
          m_pre[d]  = 0;
          m_slot[d] = (m_slot[d] + 1) % p_dpb[d];
          m_seg[d]  = 0;
          m_led[d]  = 8'hFF >> (8 - nd);
          for (int b = 0; b < p_nb[d]; b++) begin
            m_seg[d][8*b +: 8] = exp_digit(d, b * p_dpb[d] + m_slot[d], m_cnt[d], halting);
            m_led[d][b * p_dpb[d] + m_slot[d]] = 1'b0;
          end
        end else begin
          m_pre[d]++;
        end
      end
      m_den[d] = 1'b1;
      if (clear) begin
        m_cnt[d] = 0; m_ovf[d] = 0;
      end else if (!halting) begin
        if (m_cnt[d] == maxv) begin
          m_cnt[d] = 0; m_ovf[d] = 1'b1;
        end else begin
          m_cnt[d] = m_cnt[d] + 64'd1;
        end
      end
    end
  endtask

  always @(posedge clock) begin
    for (int d = 0; d < NDUT; d++) model_step(d);
  end

  always @(negedge clock) begin
    chk("a_count", 64'(count_a), m_cnt[0]);
    chk("a_ovf", 64'(ovf_a), 64'(m_ovf[0]));
    chk("a_seg", 64'(seg_a), 64'(m_seg[0]));
    chk("a_led_sel", 64'(led_a), 64'(m_led[0]));
    chk("b_count", 64'(count_b), m_cnt[1]);
    chk("b_ovf", 64'(ovf_b), 64'(m_ovf[1]));
    chk("b_seg", 64'(seg_b), 64'(m_seg[1][7:0]));
    chk("b_led_sel", 64'(led_b), 64'(m_led[1][3:0]));
  end

  task automatic run_until_count(input logic [31:0] target);
    int n = 0;
    while (count_a !== target && n < 100000) begin
      @(negedge clock);
      n++;
    end
    chk("wait_count", 64'(count_a), 64'(target));
  endtask

  task automatic wait_slot_a(input int s);
    logic [3:0] pat;
    int         n = 0;
    pat = 4'b1111 ^ (4'b0001 << s);
    do begin
      @(negedge clock);
      n++;
    end while (led_a !== {pat, pat} && n < 64);
    chk("wait_slot", 64'(led_a), 64'({pat, pat}));
  endtask

  initial begin
    logic [7:0] zdig;
    logic [3:0] prev;
    int         n;
`ifdef ZERO_BLANK_EN
    zdig = 8'h00;
`else
    zdig = 8'hFC;
`endif
    repeat (3) @(negedge clock);
    chk("rst_count", 64'(count_a), 64'd0);
    chk("rst_ovf", 64'(ovf_a), 64'd0);
    chk("rst_seg", 64'(seg_a), 64'd0);
    chk("rst_led_a", 64'(led_a), 64'hFF);
    chk("rst_led_b", 64'(led_b), 64'hF);
    $display("[TB] reset released");
    reset = 1'b0;

    // Leading-zero behaviour at count 3, held by halting.
    run_until_count(32'd3);
    halting = 1'b1;
    wait_slot_a(0);
    chk("z_g4", 64'(seg_a[15:8]), 64'(zdig));
    chk("z_status_H", 64'(seg_a[7:0]), 64'h6E);
    wait_slot_a(1);
    chk("z_g5", 64'(seg_a[15:8]), 64'(zdig));
    wait_slot_a(2);
    chk("z_g6", 64'(seg_a[15:8]), 64'(zdig));
    wait_slot_a(3);
    chk("z_g3", 64'(seg_a[7:0]), 64'(zdig));
    chk("z_g7", 64'(seg_a[15:8]), 64'hF2);
    $display("[TB] zero-digit scan at count 3 done");
    halting = 1'b0;

    wait_slot_a(0);
    chk("run_r", 64'(seg_a[7:0]), 64'h0A);
    wait_slot_a(1);
    chk("run_u", 64'(seg_a[7:0]), 64'h38);
    wait_slot_a(2);
    chk("run_n", 64'(seg_a[7:0]), 64'h2A);
    $display("[TB] run status scan done");

    run_until_count(32'h100);
    halting = 1'b1;
    repeat (50) @(negedge clock);
    chk("halt_hold", 64'(count_a), 64'h100);
    wait_slot_a(0);
    chk("halt_H", 64'(seg_a[7:0]), 64'h6E);
    wait_slot_a(1);
    chk("halt_L", 64'(seg_a[7:0]), 64'h1C);
    chk("halt_g5", 64'(seg_a[15:8]), 64'h60);
    wait_slot_a(2);
    chk("halt_t", 64'(seg_a[7:0]), 64'h1E);
    $display("[TB] halt at 0x100 done");
    halting = 1'b0;

    run_until_count(32'hFFF);
    chk("b_pre_wrap", 64'(count_b), 64'hFFF);
    chk("b_pre_ovf", 64'(ovf_b), 64'd0);
    @(negedge clock);
    chk("b_wrap", 64'(count_b), 64'd0);
    chk("b_wrap_ovf", 64'(ovf_b), 64'd1);
    chk("a_no_ovf", 64'(ovf_a), 64'd0);
    $display("[TB] 12-bit wrap done");

    run_until_count(32'h12345);
    halting = 1'b1;
    wait_slot_a(0);
    chk("d_g4", 64'(seg_a[15:8]), 64'hDA);
    wait_slot_a(1);
    chk("d_g5", 64'(seg_a[15:8]), 64'hF2);
    wait_slot_a(2);
    chk("d_g6", 64'(seg_a[15:8]), 64'h66);
    wait_slot_a(3);
    chk("d_g7", 64'(seg_a[15:8]), 64'hB6);
    chk("d_g3", 64'(seg_a[7:0]), 64'h60);
    chk("d_count", 64'(count_a), 64'h12345);
    $display("[TB] digits at 0x12345 done");

    clear = 1'b1;
    @(negedge clock);
    clear = 1'b0;
    chk("clr_count", 64'(count_a), 64'd0);
    chk("clr_ovf_b", 64'(ovf_b), 64'd0);
    repeat (5) @(negedge clock);
    chk("clr_hold", 64'(count_a), 64'd0);
    $display("[TB] clear while halted done");

    for (int k = 0; k < 2; k++) begin
      prev = led_b;
      n = 0;
      do begin @(negedge clock); n++; end while (led_b === prev && n < 20);
      prev = led_b;
      n = 0;
      do begin @(negedge clock); n++; end while (led_b === prev && n < 20);
      chk("scan_div_period", 64'(n), 64'd4);
      $display("[TB] scan period %0d measured", k);
    end

    halting = 1'b0;
    wait_slot_a(2);
    reset = 1'b1;
    @(negedge clock);
    chk("mid_rst_seg", 64'(seg_a), 64'd0);
    chk("mid_rst_led", 64'(led_a), 64'hFF);
    chk("mid_rst_count", 64'(count_a), 64'd0);
    chk("mid_rst_ovf", 64'(ovf_a), 64'd0);
    chk("mid_rst_led_b", 64'(led_b), 64'hF);
    $display("[TB] mid-scan reset done");
    reset = 1'b0;
    repeat (10) @(negedge clock);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
